// File: rtl/sweep_result_reader.sv
// ============================================================================
// Module      : sweep_result_reader
// Description : Captures per-point sweep results (modulus, phase) into two
//               result memories while armed. A host reads them back through
//               a one-cycle-latency read port, which also exposes status,
//               accepted-result count and an optional checksum.
//               Optional feature macro: SWEEP_READER_CHECKSUM_EN
//               (32-bit wrapping sum of modulo+phase over accepted writes).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sweep_result_reader #(
    parameter int DEPTH      = 200,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk125,
    input  logic                  reset,
    input  logic                  valid_m,
    input  logic [DATA_WIDTH-1:0] modulo,
    input  logic [DATA_WIDTH-1:0] phase,
    input  logic [7:0]            point_addr,
    input  logic                  sweep_fin,
    input  logic                  arm,
    input  logic                  rd_en,
    input  logic [9:0]            rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_ack,
    output logic                  busy,
    output logic                  done,
    output logic [8:0]            count
);

    localparam logic [8:0] c_DEPTH9    = 9'(DEPTH);
    localparam logic [8:0] c_COUNT_MAX = 9'h1FF;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t                state_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  overrun_q;
    logic                  addr_err_q;
    logic [8:0]            count_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_ack_q;

    logic [DATA_WIDTH-1:0] mod_mem [DEPTH];
    logic [DATA_WIDTH-1:0] ph_mem  [DEPTH];

    logic                  w_capturing;
    logic                  w_pt_in_range;
    logic                  w_accept;
    logic                  w_rd_in_range;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic [DATA_WIDTH-1:0] w_checksum;

    // Qualify an incoming result: only ARMED/CAPTURE accept, arm drops it
    always_comb begin
        w_capturing   = (state_q == S_ARMED) || (state_q == S_CAPTURE);
        w_pt_in_range = ({1'b0, point_addr} < c_DEPTH9);
        w_accept      = valid_m && w_capturing && w_pt_in_range && !arm && !reset;
        w_rd_in_range = ({1'b0, rd_addr[7:0]} < c_DEPTH9);
    end

    // Capture control FSM with registered busy/done, count and sticky flags
    always_ff @(posedge clk125) begin
        if (reset) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
            addr_err_q <= 1'b0;
            count_q    <= 9'd0;
        end else if (arm) begin
            state_q    <= S_ARMED;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
            addr_err_q <= 1'b0;
            count_q    <= 9'd0;
        end else begin
            case (state_q)
                S_ARMED, S_CAPTURE: begin
                    if (valid_m && !w_pt_in_range) begin
                        addr_err_q <= 1'b1;
                    end
                    if (w_accept && (count_q != c_COUNT_MAX)) begin
                        count_q <= count_q + 9'd1;
                    end
                    // A result arriving with sweep_fin is still taken above
                    if (sweep_fin) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (w_accept) begin
                        state_q <= S_CAPTURE;
                    end
                end
                S_DONE: begin
                    if (valid_m) begin
                        overrun_q <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Result memories: not reset, written only with accepted results
    always_ff @(posedge clk125) begin
        if (w_accept) begin
            mod_mem[point_addr] <= modulo;
            ph_mem[point_addr]  <= phase;
        end
    end

`ifdef SWEEP_READER_CHECKSUM_EN
    logic [31:0] checksum_q;

    // Wrapping sum of modulo+phase over every accepted result since arm
    always_ff @(posedge clk125) begin
        if (reset || arm) begin
            checksum_q <= 32'd0;
        end else if (w_accept) begin
            checksum_q <= checksum_q + 32'(signed'(modulo)) + 32'(signed'(phase));
        end
    end

    assign w_checksum = DATA_WIDTH'(checksum_q);
`else
    assign w_checksum = '0;
`endif

    // Read address decode; memory reads see pre-write contents this cycle
    always_comb begin
        w_rd_word = '0;
        case (rd_addr[9:8])
            2'b00: begin
                if (w_rd_in_range) begin
                    w_rd_word = mod_mem[rd_addr[7:0]];
                end
            end
            2'b01: begin
                if (w_rd_in_range) begin
                    w_rd_word = ph_mem[rd_addr[7:0]];
                end
            end
            2'b10: begin
                case (rd_addr[7:0])
                    8'h00:   w_rd_word = {{(DATA_WIDTH-4){1'b0}}, addr_err_q, overrun_q, done_q, busy_q};
                    8'h01:   w_rd_word = {{(DATA_WIDTH-9){1'b0}}, count_q};
                    8'h02:   w_rd_word = w_checksum;
                    default: w_rd_word = '0;
                endcase
            end
            default: w_rd_word = '0;
        endcase
    end

    // Read port: ack one cycle after every request, data held otherwise
    always_ff @(posedge clk125) begin
        if (reset) begin
            rd_ack_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            rd_ack_q <= rd_en;
            if (rd_en) begin
                rd_data_q <= w_rd_word;
            end
        end
    end

    assign rd_data = rd_data_q;
    assign rd_ack  = rd_ack_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign count   = count_q;

endmodule

`default_nettype wire

// File: tb/tb_sweep_result_reader.sv
// ============================================================================
// Module      : tb_sweep_result_reader
// Description : Self-checking bench for sweep_result_reader. A behavioural
//               model tracks expected outputs; directed scenarios add
//               hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sweep_result_reader;

    localparam int DEPTH = 200;
    localparam int DW    = 32;

`ifdef SWEEP_READER_CHECKSUM_EN
    localparam logic [31:0] c_CS_17  = 32'd17;
    localparam logic [31:0] c_CS_SAT = 32'd132355;
`else
    localparam logic [31:0] c_CS_17  = 32'd0;
    localparam logic [31:0] c_CS_SAT = 32'd0;
`endif

    logic          clk125 = 1'b0;
    logic          reset;
    logic          valid_m;
    logic [DW-1:0] modulo;
    logic [DW-1:0] phase;
    logic [7:0]    point_addr;
    logic          sweep_fin;
    logic          arm;
    logic          rd_en;
    logic [9:0]    rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_ack;
    logic          busy;
    logic          done;
    logic [8:0]    count;

    int checks = 0;
    int errors = 0;

    always #5 clk125 = ~clk125;

    sweep_result_reader #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .clk125     (clk125),
        .reset      (reset),
        .valid_m    (valid_m),
        .modulo     (modulo),
        .phase      (phase),
        .point_addr (point_addr),
        .sweep_fin  (sweep_fin),
        .arm        (arm),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_ack     (rd_ack),
        .busy       (busy),
        .done       (done),
        .count      (count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: capture window, results, flags, expected read
    // ------------------------------------------------------------------
    logic [31:0] m_mod [256];
    logic [31:0] m_ph  [256];
    bit          m_mod_known [256];
    bit          m_ph_known  [256];
    bit          m_window;   // results are being collected
    bit          m_finished; // sweep completed, waiting for arm
    bit          m_over;
    bit          m_aerr;
    int          m_count;
    logic [31:0] m_sum;
    logic [31:0] e_data;
    bit          e_known = 1'b0;
    bit          e_ack;
    bit          m_live = 1'b0;

    always @(posedge clk125) begin
        if (reset) begin
            m_window = 0; m_finished = 0; m_over = 0; m_aerr = 0;
            m_count = 0; m_sum = 0; e_ack = 0; e_data = 0; e_known = 1; m_live = 1;
        end else if (m_live) begin
            e_ack = rd_en;
            if (rd_en) begin
                int a;
                a = int'(rd_addr);
                e_known = 1; e_data = 0;
                if (a < 256) begin
                    if (a < DEPTH) begin e_known = m_mod_known[a]; e_data = m_mod[a]; end
                end else if (a < 512) begin
                    if (a - 256 < DEPTH) begin e_known = m_ph_known[a-256]; e_data = m_ph[a-256]; end
                end else if (a == 512) begin
                    e_data = {28'd0, m_aerr, m_over, m_finished, m_window};
                end else if (a == 513) begin
                    e_data = 32'(m_count);
                end else if (a == 514) begin
`ifdef SWEEP_READER_CHECKSUM_EN
                    e_data = m_sum;
`endif
                end
            end
            if (arm) begin
                m_window = 1; m_finished = 0; m_over = 0; m_aerr = 0; m_count = 0; m_sum = 0;
            end else if (m_window) begin
                if (valid_m) begin
                    if (int'(point_addr) < DEPTH) begin
                        m_mod[point_addr] = modulo; m_mod_known[point_addr] = 1;
                        m_ph[point_addr]  = phase;  m_ph_known[point_addr]  = 1;
                        if (m_count < 511) m_count++;
                        m_sum = m_sum + modulo + phase;
                    end else begin
                        m_aerr = 1;
                    end
                end
                if (sweep_fin) begin m_window = 0; m_finished = 1; end
            end else if (m_finished && valid_m) begin
                m_over = 1;
            end
        end
    end

    // Compare DUT outputs against the model every cycle, mid-period
    always @(negedge clk125) begin
        if (m_live) begin
            check("model_rd_ack", 32'(rd_ack), 32'(e_ack));
            check("model_busy", 32'(busy), 32'(m_window));
            check("model_done", 32'(done), 32'(m_finished));
            check("model_count", 32'(count), 32'(m_count));
            if (e_known) check("model_rd_data", rd_data, e_data);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk125);
        #2;
    endtask

    task automatic wr(input logic [7:0] pa, input logic [31:0] m, input logic [31:0] p);
        valid_m = 1; point_addr = pa; modulo = m; phase = p;
        step();
        valid_m = 0;
    endtask

    task automatic rd(input logic [9:0] a, input logic [31:0] exp, input string name);
        rd_en = 1; rd_addr = a;
        step();
        rd_en = 0;
        check({name, "_ack"}, 32'(rd_ack), 32'd1);
        check(name, rd_data, exp);
    endtask

    task automatic pulse_arm();
        arm = 1;
        step();
        arm = 0;
    endtask

    initial begin
        reset = 1; valid_m = 0; modulo = 0; phase = 0; point_addr = 0;
        sweep_fin = 0; arm = 0; rd_en = 1; rd_addr = 10'h200;

        // Reset with a read pending: no ack may come out of it
        repeat (3) step();
        reset = 0; rd_en = 0;
        check("reset_ack", 32'(rd_ack), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_count", 32'(count), 32'd0);
        rd(10'h200, 32'h0, "reset_status");

        // Results and sweep_fin in IDLE have no effect
        wr(8'd5, 32'h99, 32'h1);
        sweep_fin = 1; step(); sweep_fin = 0;
        check("idle_count", 32'(count), 32'd0);
        check("idle_done", 32'(done), 32'd0);

        // Full sweep: modulo=i, phase=-i
        pulse_arm();
        check("arm_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 200; i++) wr(8'(i), 32'(i), 32'(-i));
        sweep_fin = 1; step(); sweep_fin = 0;
        check("sweep_done", 32'(done), 32'd1);
        check("sweep_busy", 32'(busy), 32'd0);
        check("sweep_count", 32'(count), 32'd200);
        rd(10'h005, 32'd5, "sweep_mod5");
        rd(10'h105, 32'hFFFF_FFFB, "sweep_ph5");
        rd(10'h200, 32'h2, "sweep_status");

        // Back-to-back reads
        rd_en = 1; rd_addr = 10'h000; step();
        check("b2b0_ack", 32'(rd_ack), 32'd1); check("b2b0_data", rd_data, 32'd0);
        rd_addr = 10'h201; step();
        check("b2b1_ack", 32'(rd_ack), 32'd1); check("b2b1_data", rd_data, 32'd200);
        rd_addr = 10'h3FF; step();
        check("b2b2_ack", 32'(rd_ack), 32'd1); check("b2b2_data", rd_data, 32'd0);
        rd_en = 0; step();
        check("b2b_ack_low", 32'(rd_ack), 32'd0);
        check("b2b_hold", rd_data, 32'd0);

        // Out-of-range point while ARMED
        pulse_arm();
        wr(8'd200, 32'h1, 32'h1);
        rd(10'h200, 32'h9, "aerr_status");
        rd(10'h201, 32'h0, "aerr_count");

        // Result together with sweep_fin, then a late result -> overrun
        pulse_arm();
        wr(8'd3, 32'h33, 32'h30);
        valid_m = 1; point_addr = 8'd4; modulo = 32'h44; phase = 32'h40; sweep_fin = 1;
        step();
        valid_m = 0; sweep_fin = 0;
        check("fin_done", 32'(done), 32'd1);
        check("fin_count", 32'(count), 32'd2);
        wr(8'd6, 32'h66, 32'h0);
        rd(10'h200, 32'h6, "overrun_status");
        rd(10'h006, 32'd6, "overrun_nowrite");
        rd(10'h004, 32'h44, "fin_write");

        // arm with a same-cycle result during CAPTURE
        pulse_arm();
        wr(8'd10, 32'h1010, 32'h0);
        check("cap_count", 32'(count), 32'd1);
        arm = 1; valid_m = 1; point_addr = 8'd7; modulo = 32'hDEAD; phase = 32'hBEEF;
        step();
        arm = 0; valid_m = 0;
        check("rearm_count", 32'(count), 32'd0);
        check("rearm_busy", 32'(busy), 32'd1);
        rd(10'h007, 32'd7, "rearm_dropped");

        // Checksum over (10,5),(3,-1)
        wr(8'd0, 32'd10, 32'd5);
        wr(8'd1, 32'd3, 32'hFFFF_FFFF);
        rd(10'h202, c_CS_17, "checksum");

        // Read and write to the same word in one cycle
        valid_m = 1; point_addr = 8'd2; modulo = 32'h55; phase = 32'h77;
        rd_en = 1; rd_addr = 10'h002;
        step();
        valid_m = 0; rd_en = 0;
        check("rw_same_ack", 32'(rd_ack), 32'd1);
        check("rw_same_old", rd_data, 32'd2);
        rd(10'h002, 32'h55, "rw_new_mod");
        rd(10'h102, 32'h77, "rw_new_ph");

        // Reset mid-capture
        reset = 1; step(); reset = 0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_count", 32'(count), 32'd0);
        rd(10'h200, 32'h0, "midrst_status");
        rd(10'h202, 32'h0, "midrst_checksum");
        rd(10'h005, 32'd5, "midrst_mem_kept");

        // Count saturation
        pulse_arm();
        for (int i = 0; i < 515; i++) wr(8'(i % 200), 32'(i), 32'h0);
        check("sat_count", 32'(count), 32'd511);
        sweep_fin = 1; step(); sweep_fin = 0;
        rd(10'h201, 32'd511, "sat_count_rd");
        rd(10'h202, c_CS_SAT, "sat_checksum");

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sweep_result_reader.md
SWEEP_RESULT_READER -- requirements
Module: sweep_result_reader

Interface
REQ-001 SHALL have parameter DEPTH, default 200, meaning number of valid sweep points (indices 0..DEPTH-1).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning width of modulo, phase and read data.
REQ-003 SHALL use one clock with synchronous, active-high reset.
REQ-004 SHALL provide port clk125, input, 1, system clock; all logic on rising edge.
REQ-005 SHALL provide port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL provide port valid_m, input, 1, one-cycle result strobe from the measurement path.
REQ-007 SHALL provide port modulo, input, DATA_WIDTH, signed impedance-modulus result qualified by valid_m.
REQ-008 SHALL provide port phase, input, DATA_WIDTH, signed phase result qualified by valid_m.
REQ-009 SHALL provide port point_addr, input, 8, sweep index of the result qualified by valid_m.
REQ-010 SHALL provide port sweep_fin, input, 1, level high when the sweep has finished.
REQ-011 SHALL provide port arm, input, 1, one-cycle pulse that clears status and starts a capture.
REQ-012 SHALL provide port rd_en, input, 1, host read request.
REQ-013 SHALL provide port rd_addr, input, 10, host read word address.
REQ-014 SHALL provide port rd_data, output, DATA_WIDTH, host read data.
REQ-015 SHALL provide port rd_ack, output, 1, read data valid strobe.
REQ-016 SHALL provide port busy, output, 1, high in ARMED or CAPTURE.
REQ-017 SHALL provide port done, output, 1, high in DONE.
REQ-018 SHALL provide port count, output, 9, number of accepted results since last arm.

Function
REQ-019 SHALL implement FSM IDLE, ARMED, CAPTURE, DONE; IDLE after reset.
REQ-020 SHALL, on arm in any state, next cycle enter ARMED, clear count, overrun, addr_err and checksum; arm wins over a same-cycle valid_m, which is dropped.
REQ-021 SHALL, in ARMED or CAPTURE, accept valid_m with point_addr < DEPTH: write modulo to mod_mem[point_addr], phase to ph_mem[point_addr], increment count (saturating at 511); ARMED moves to CAPTURE on first accepted write.
REQ-022 SHALL drop valid_m with point_addr >= DEPTH and set sticky addr_err.
REQ-023 SHALL ignore valid_m in IDLE; valid_m in DONE is not written and sets sticky overrun.
REQ-024 SHALL move ARMED or CAPTURE to DONE the cycle after sweep_fin is sampled high; a valid_m in that same cycle is still accepted.
REQ-025 SHALL hold DONE until arm; sweep_fin in IDLE or DONE has no effect.
REQ-026 SHALL answer every rd_en with rd_ack exactly one cycle later, rd_data registered in that cycle; back-to-back rd_en gives back-to-back rd_ack.
REQ-027 SHALL decode rd_addr: 0x000-0x0FF mod_mem[rd_addr[7:0]], 0x100-0x1FF ph_mem[rd_addr[7:0]], 0x200 status {28'b0, addr_err, overrun, done, busy}, 0x201 zero-extended count, 0x202 checksum, all other addresses 0.
REQ-028 SHALL return pre-write data when read and write address the same memory word in the same cycle.
REQ-029 SHALL hold rd_data at its last value when rd_ack is low.

Reset
REQ-030 SHALL, on reset, set state IDLE, rd_data 0, rd_ack 0, busy 0, done 0, count 0, overrun 0, addr_err 0, checksum 0.
REQ-031 SHALL not clear memory contents on reset; reads of unwritten entries return unspecified data.
REQ-032 SHALL abort any capture on reset mid-operation and discard an rd_en pending in the reset cycle (no rd_ack).

Configuration
REQ-033 SHALL, with macro SWEEP_READER_CHECKSUM_EN defined, keep a 32-bit wrapping sum of modulo+phase over accepted writes, readable at 0x202.
REQ-034 SHALL, without SWEEP_READER_CHECKSUM_EN, omit checksum logic; 0x202 reads 0.

Verification
REQ-035 SHALL cover: reset, arm, 200 valid_m with point_addr 0..199, modulo=i, phase=-i, sweep_fin -> done=1, count=200, read 0x005=5, 0x105=0xFFFFFFFB.
REQ-036 SHALL cover: valid_m point_addr=200 while ARMED -> status=0x9 (addr_err, busy), count=0.
REQ-037 SHALL cover: valid_m and sweep_fin same cycle in CAPTURE -> write accepted, count+1, done next cycle; later valid_m -> overrun, status=0x6.
REQ-038 SHALL cover: arm and valid_m same cycle during CAPTURE -> valid dropped, count=0, busy=1.
REQ-039 SHALL cover: rd_en on consecutive cycles to 0x000, 0x201, 0x3FF -> rd_ack on following three cycles, data mod_mem[0], count, 0.
REQ-040 SHALL cover: with SWEEP_READER_CHECKSUM_EN, writes (modulo,phase)=(10,5),(3,-1) -> 0x202 reads 17; without macro reads 0.
